esp_dma_read_engine: RTL



---
 rtl/esp_dma_read_engine_if.sv | 48 ++++
 rtl/esp_dma_read_engine.sv | 122 ++++++++++++
 2 files changed

// File: rtl/esp_dma_read_engine_if.sv
// Bundle of the accelerator-side DMA read handshakes and the memory-side
// burst request / response handshakes. The engine uses the slave view, the
// accelerator/memory side (or a bench) uses the master view.
interface esp_dma_read_engine_if #(
  parameter int MAX_BURST = 16
);
  localparam int LW = $clog2(MAX_BURST) + 1;

  logic          dma_read_ctrl_valid;
  logic [31:0]   dma_read_ctrl_data_index;
  logic [31:0]   dma_read_ctrl_data_length;
  logic          dma_read_ctrl_ready;

  logic          dma_read_chnl_valid;
  logic [31:0]   dma_read_chnl_data;
  logic          dma_read_chnl_ready;

  logic          mem_req_valid;
  logic [31:0]   mem_req_index;
  logic [LW-1:0] mem_req_length;
  logic          mem_req_ready;

  logic          mem_rsp_valid;
  logic [31:0]   mem_rsp_data;
  logic          mem_rsp_ready;

  modport slave (
    input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
    output dma_read_ctrl_ready,
    output dma_read_chnl_valid, dma_read_chnl_data,
    input  dma_read_chnl_ready,
    output mem_req_valid, mem_req_index, mem_req_length,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output mem_rsp_ready
  );

  modport master (
    output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
    input  dma_read_ctrl_ready,
    input  dma_read_chnl_valid, dma_read_chnl_data,
    output dma_read_chnl_ready,
    input  mem_req_valid, mem_req_index, mem_req_length,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  mem_rsp_ready
  );
endinterface

// File: rtl/esp_dma_read_engine.sv
// DMA read engine: splits an accelerator read request into memory bursts
// bounded by MAX_BURST and page edges, buffers the returned words in a FIFO
// and streams them to the accelerator in order. One burst in flight at a time.
module esp_dma_read_engine #(
  parameter int MAX_BURST  = 16,
  parameter int PAGE_WORDS = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  esp_dma_read_engine_if.slave          bus,
  output logic                          busy
);
  localparam int LW = $clog2(MAX_BURST) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]    state;
  logic [31:0]   cur_idx;
  logic [31:0]   remain;
  logic [31:0]   blen_q;     // length of the burst currently returning data
  logic [LW-1:0] beat_cnt;

  logic [31:0]   page_left;
  logic [31:0]   blen;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          rsp_ready;
  logic          last_beat;

  // Next burst length: the smallest of what is left, the burst cap and the
  // distance to the next page edge. Depends only on registered state, so it
  // stays stable for the whole REQ phase.
  always_comb begin
    page_left = 32'(PAGE_WORDS) - (cur_idx & 32'(PAGE_WORDS - 1));
    blen      = remain;
    if (blen > 32'(MAX_BURST)) blen = 32'(MAX_BURST);
    if (blen > page_left)      blen = page_left;
  end

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rsp_ready = (state == DATA) && !full;
  assign push      = bus.mem_rsp_valid && rsp_ready;
  assign pop       = !empty && bus.dma_read_chnl_ready;
  assign last_beat = (32'(beat_cnt) + 32'd1 == blen_q);

  assign bus.dma_read_ctrl_ready = (state == IDLE);
  assign bus.mem_req_valid       = (state == REQ);
  assign bus.mem_req_index       = (state == REQ) ? cur_idx : 32'd0;
  assign bus.mem_req_length      = (state == REQ) ? blen[LW-1:0] : '0;
  assign bus.mem_rsp_ready       = rsp_ready;
  assign bus.dma_read_chnl_valid = !empty;
  assign bus.dma_read_chnl_data  = empty ? 32'd0 : fifo_mem[rd_ptr[AW-1:0]];
  assign busy                    = (state != IDLE);

  // Request sequencing: accept in IDLE, issue one burst, collect its beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_idx  <= 32'd0;
      remain   <= 32'd0;
      blen_q   <= 32'd0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dma_read_ctrl_valid) begin
            cur_idx <= bus.dma_read_ctrl_data_index;
            remain  <= bus.dma_read_ctrl_data_length;
            if (bus.dma_read_ctrl_data_length != 32'd0) state <= REQ;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            blen_q   <= blen;
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (push) begin
            if (last_beat) begin
              cur_idx  <= cur_idx + blen_q;   // wraps modulo 2^32
              remain   <= remain - blen_q;
              beat_cnt <= '0;
              state    <= (remain == blen_q) ? IDLE : REQ;
            end else begin
              beat_cnt <= beat_cnt + LW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers; an extra wrap bit tells full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.mem_rsp_data;
  end
endmodule
